// File: rtl/picmicro_interrupt_controller_if.sv
// Purpose: bundles the decoder/INTCON/PIR1/PIE1 side of the PIC interrupt controller.
// Latency: wiring only, no storage.
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface picmicro_interrupt_controller_if;
  logic       instr_boundary;
  logic       retfie_exec;
  logic       sleep_active;
  logic [7:0] intcon_reg_val;
  logic [7:0] pir1_reg_val;
  logic [7:0] pie1_reg_val;
  logic       tmr0if_set_en;
  logic       int_pin;
  logic       intedg;
  logic       irq_take;
  logic       gie_clr_en;
  logic       gie_set_en;
  logic       t0if_set_en;
  logic       intf_set_en;
  logic       wake_req;
  logic       irq_busy;

  // Core side: drives the decoder strobes and register views, receives requests.
  modport master (
    output instr_boundary, retfie_exec, sleep_active,
    output intcon_reg_val, pir1_reg_val, pie1_reg_val,
    output tmr0if_set_en, int_pin, intedg,
    input  irq_take, gie_clr_en, gie_set_en, t0if_set_en,
    input  intf_set_en, wake_req, irq_busy
  );

  // Controller side.
  modport slave (
    input  instr_boundary, retfie_exec, sleep_active,
    input  intcon_reg_val, pir1_reg_val, pie1_reg_val,
    input  tmr0if_set_en, int_pin, intedg,
    output irq_take, gie_clr_en, gie_set_en, t0if_set_en,
    output intf_set_en, wake_req, irq_busy
  );
endinterface

// File: rtl/picmicro_interrupt_controller.sv
// Purpose: PIC interrupt sequencer (IDLE/VECTOR/ISR); RB0/INT pin logic under PICMICRO_INT_PIN_EN.
// Latency: irq_take 1 cycle after a qualifying boundary; gie_set_en/t0if_set_en/wake_req 1 cycle; intf_set_en 3 cycles.
// Backpressure: none; one vector at a time, no nesting while an ISR is in progress.
module picmicro_interrupt_controller (
  input  logic clk,
  input  logic rst,
  picmicro_interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, VECTOR = 2'd1, ISR = 2'd2} state_t;

  state_t state, state_nxt;
  logic   enabled_flag;
  logic   irq_cond;
  logic   gie_set_q;
  logic   t0if_set_q;
  logic   wake_q;
  logic   intf_set_q;

  // Any enabled source with its flag raised; GIE only gates vectoring, not wake.
  always_comb begin
    enabled_flag = (bus.intcon_reg_val[5] & bus.intcon_reg_val[2])
                 | (bus.intcon_reg_val[4] & bus.intcon_reg_val[1])
                 | (bus.intcon_reg_val[3] & bus.intcon_reg_val[0])
                 | (bus.intcon_reg_val[6] & (|(bus.pir1_reg_val & bus.pie1_reg_val)));
    irq_cond     = bus.intcon_reg_val[7] & enabled_flag;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: vector only on an instruction boundary; RETFIE wins over a new request in ISR.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.instr_boundary && irq_cond) state_nxt = VECTOR;
      VECTOR:  state_nxt = ISR;
      ISR:     if (bus.retfie_exec) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: the single VECTOR cycle forces the CALL and clears GIE.
  always_comb begin
    bus.irq_take   = 1'b0;
    bus.gie_clr_en = 1'b0;
    bus.irq_busy   = 1'b0;
    case (state)
      VECTOR: begin
        bus.irq_take   = 1'b1;
        bus.gie_clr_en = 1'b1;
        bus.irq_busy   = 1'b1;
      end
      ISR:     bus.irq_busy = 1'b1;
      default: ;
    endcase
  end

  // Registered side pulses; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      gie_set_q  <= 1'b0;
      t0if_set_q <= 1'b0;
      wake_q     <= 1'b0;
    end else begin
      gie_set_q  <= bus.retfie_exec;
      t0if_set_q <= bus.tmr0if_set_en;
      wake_q     <= bus.sleep_active & enabled_flag;
    end
  end

`ifdef PICMICRO_INT_PIN_EN
  logic       pin_sync1;
  logic       pin_sync2;
  logic       pin_hist;
  logic [1:0] warm_cnt;
  logic       pin_edge;

  // Edge of the selected polarity between the synchronized sample and its history.
  always_comb begin
    pin_edge = bus.intedg ? (pin_sync2 & ~pin_hist) : (~pin_sync2 & pin_hist);
  end

  // Two-flop synchronizer, history flop, and a warm-up count so post-reset fill never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pin_sync1  <= 1'b0;
      pin_sync2  <= 1'b0;
      pin_hist   <= 1'b0;
      warm_cnt   <= 2'd0;
      intf_set_q <= 1'b0;
    end else begin
      pin_sync1  <= bus.int_pin;
      pin_sync2  <= pin_sync1;
      pin_hist   <= pin_sync2;
      if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
      intf_set_q <= pin_edge & (warm_cnt == 2'd3);
    end
  end
`else
  logic unused_pin;

  // Pin logic absent: the pin inputs are deliberately ignored.
  always_comb begin
    unused_pin = bus.int_pin ^ bus.intedg;
    intf_set_q = 1'b0;
  end
`endif

  // Drive the registered outputs onto the bus.
  always_comb begin
    bus.gie_set_en  = gie_set_q;
    bus.t0if_set_en = t0if_set_q;
    bus.wake_req    = wake_q;
    bus.intf_set_en = intf_set_q;
  end

endmodule

// File: tb/tb_picmicro_interrupt_controller.sv
// Purpose: scoreboard bench for picmicro_interrupt_controller with directed vectors.
// Latency: each stimulus cycle queues the outputs expected after the next clock edge.
// Backpressure: none; the monitor drains the queue once per cycle on the falling edge.
module tb_picmicro_interrupt_controller;

    localparam logic [6:0] TAKE = 7'b1000000;
    localparam logic [6:0] CLR  = 7'b0100000;
    localparam logic [6:0] SET  = 7'b0010000;
    localparam logic [6:0] T0   = 7'b0001000;
    localparam logic [6:0] INTF = 7'b0000100;
    localparam logic [6:0] WAKE = 7'b0000010;
    localparam logic [6:0] BUSY = 7'b0000001;
    localparam logic [6:0] VEC  = TAKE | CLR | BUSY;

`ifdef PICMICRO_INT_PIN_EN
    localparam logic [6:0] PIN_PULSE = INTF;
`else
    localparam logic [6:0] PIN_PULSE = 7'b0000000;
`endif

    typedef struct {
        int         cyc;
        logic [6:0] e;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];
    exp_t cur;
    logic [6:0] act;

    picmicro_interrupt_controller_if bus();

    picmicro_interrupt_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has come.
    always @(negedge clk) begin
        act = {bus.irq_take, bus.gie_clr_en, bus.gie_set_en, bus.t0if_set_en,
               bus.intf_set_en, bus.wake_req, bus.irq_busy};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            cur = q.pop_front();
            vectors++;
            if (cur.cyc != cyc || act !== cur.e) begin
                miscompares++;
                $display("FAIL %s cyc=%0d: got %b expected %b (take,clr,set,t0,intf,wake,busy)",
                         cur.nm, cyc, act, cur.e);
            end
        end
    end

    // Queue the outputs expected after the coming edge, then advance one cycle.
    task automatic tick(input string nm, input logic [6:0] e);
        exp_t x;
        x.cyc = cyc + 1;
        x.e   = e;
        x.nm  = nm;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.instr_boundary = 0; bus.retfie_exec = 0; bus.sleep_active = 0;
        bus.intcon_reg_val = 8'h00; bus.pir1_reg_val = 8'h00; bus.pie1_reg_val = 8'h00;
        bus.tmr0if_set_en = 0; bus.int_pin = 0; bus.intedg = 1;
        @(posedge clk); #1;

        // Reset state.
        tick("reset0", 7'b0);
        tick("reset1", 7'b0);
        rst = 1'b0;
        tick("idle", 7'b0);
        vectors++;
        if (bus.irq_take !== 1'b0 || bus.irq_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL direct_idle: irq_take=%b irq_busy=%b", bus.irq_take, bus.irq_busy);
        end

        // T0 interrupt: pending condition without a boundary does nothing.
        bus.intcon_reg_val = 8'hA4;
        tick("cond_no_boundary0", 7'b0);
        tick("cond_no_boundary1", 7'b0);
        bus.instr_boundary = 1;
        tick("t0_vector", VEC);
        vectors++;
        if (bus.irq_take !== 1'b1 || bus.gie_clr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL direct_vector: irq_take=%b gie_clr_en=%b", bus.irq_take, bus.gie_clr_en);
        end
        bus.instr_boundary = 0;
        tick("t0_isr", BUSY);
        vectors++;
        if (bus.irq_take !== 1'b0 || bus.irq_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL direct_isr: irq_take=%b irq_busy=%b", bus.irq_take, bus.irq_busy);
        end
        bus.instr_boundary = 1;
        tick("isr_boundary_ignored", BUSY);
        bus.instr_boundary = 0;
        tick("isr_hold", BUSY);

        // RETFIE leaves ISR and restores GIE one cycle later.
        bus.intcon_reg_val = 8'h24;
        bus.retfie_exec = 1;
        tick("retfie_isr", SET);
        vectors++;
        if (bus.gie_set_en !== 1'b1 || bus.irq_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL direct_retfie: gie_set_en=%b irq_busy=%b", bus.gie_set_en, bus.irq_busy);
        end
        bus.retfie_exec = 0;
        tick("after_retfie", 7'b0);

        // RETFIE in IDLE still pulses gie_set_en.
        bus.retfie_exec = 1;
        tick("retfie_idle", SET);
        bus.retfie_exec = 0;
        tick("retfie_idle_done", 7'b0);

        // Peripheral source via PIE1/PIR1.
        bus.intcon_reg_val = 8'hC0; bus.pie1_reg_val = 8'h01; bus.pir1_reg_val = 8'h01;
        bus.instr_boundary = 1;
        tick("periph_vector", VEC);
        bus.instr_boundary = 0;
        tick("periph_isr", BUSY);
        bus.retfie_exec = 1;
        tick("periph_retfie", SET);
        bus.retfie_exec = 0;
        bus.pie1_reg_val = 8'h00;
        bus.instr_boundary = 1;
        tick("periph_masked", 7'b0);
        bus.instr_boundary = 0;
        tick("periph_masked_idle", 7'b0);
        bus.intcon_reg_val = 8'h00; bus.pir1_reg_val = 8'h00;

        // RETFIE with boundary and pending condition in ISR returns to IDLE first.
        bus.intcon_reg_val = 8'hA4;
        bus.instr_boundary = 1;
        tick("race_vector", VEC);
        bus.instr_boundary = 0;
        tick("race_isr", BUSY);
        bus.retfie_exec = 1; bus.instr_boundary = 1;
        tick("race_retfie", SET);
        bus.retfie_exec = 0; bus.instr_boundary = 0;
        tick("race_idle_wait", 7'b0);
        bus.instr_boundary = 1;
        tick("race_retake", VEC);
        // RETFIE during VECTOR pulses gie_set_en but does not disturb the sequence.
        bus.instr_boundary = 0; bus.retfie_exec = 1;
        tick("retfie_in_vector", BUSY | SET);
        bus.retfie_exec = 0;
        tick("vector_to_isr_hold", BUSY);
        bus.retfie_exec = 1;
        tick("race_exit", SET);
        bus.retfie_exec = 0;
        bus.intcon_reg_val = 8'h00;
        tick("race_done", 7'b0);

        // TMR0 overflow pulse re-timed by one cycle.
        bus.tmr0if_set_en = 1;
        tick("t0if_pulse", T0);
        bus.tmr0if_set_en = 0;
        tick("t0if_end", 7'b0);

        // SLEEP wake with GIE clear: wake but never vector.
        bus.sleep_active = 1;
        tick("sleep_no_flag", 7'b0);
        bus.intcon_reg_val = 8'h24;
        tick("wake_gie0", WAKE);
        tick("wake_hold", WAKE);
        bus.intcon_reg_val = 8'h20;
        tick("wake_clear", 7'b0);

        // SLEEP with GIE set: vector only once a boundary arrives.
        bus.intcon_reg_val = 8'hA4;
        tick("wake_gie1", WAKE);
        tick("wake_gie1_nobnd", WAKE);
        bus.instr_boundary = 1;
        tick("wake_then_vector", WAKE | VEC);
        bus.instr_boundary = 0; bus.sleep_active = 0;
        tick("wake_isr", BUSY);
        bus.retfie_exec = 1;
        tick("wake_retfie", SET);
        bus.retfie_exec = 0;
        bus.intcon_reg_val = 8'h00;
        tick("wake_done", 7'b0);

        // Reset during VECTOR: back to IDLE, pending pulses dropped.
        bus.intcon_reg_val = 8'hA4;
        bus.instr_boundary = 1;
        tick("rst_pre_vector", VEC);
        bus.instr_boundary = 0;
        rst = 1; bus.retfie_exec = 1; bus.tmr0if_set_en = 1;
        tick("rst_in_vector", 7'b0);
        rst = 0; bus.retfie_exec = 0; bus.tmr0if_set_en = 0;
        tick("rst_after0", 7'b0);
        tick("rst_after1", 7'b0);
        bus.intcon_reg_val = 8'h00;

        // External pin, rising edge selected.
        bus.intedg = 1; bus.int_pin = 0;
        tick("pin_low0", 7'b0);
        tick("pin_low1", 7'b0);
        bus.int_pin = 1;
        tick("pin_rise_s1", 7'b0);
        tick("pin_rise_s2", 7'b0);
        tick("pin_rise_pulse", PIN_PULSE);
        tick("pin_rise_end", 7'b0);
        // Falling edge selected: the same rising stimulus gives nothing.
        bus.intedg = 0;
        bus.int_pin = 0;
        tick("pin_fall_s1", 7'b0);
        tick("pin_fall_s2", 7'b0);
        tick("pin_fall_pulse", PIN_PULSE);
        tick("pin_fall_end", 7'b0);
        bus.int_pin = 1;
        tick("pin_rise_ign0", 7'b0);
        tick("pin_rise_ign1", 7'b0);
        tick("pin_rise_ign2", 7'b0);
        tick("pin_rise_ign3", 7'b0);
        // Pin already high across reset: the fill after reset is not an edge.
        bus.intedg = 1;
        rst = 1;
        tick("pin_rst", 7'b0);
        rst = 0;
        for (int i = 0; i < 5; i++) tick("pin_post_rst", 7'b0);

        tick("drain", 7'b0);
        @(negedge clk); #1;
        while (q.size() > 0) begin
            cur = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: expectation never checked, expected %b", cur.nm, cur.e);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares == 0) $display("PASS");
        else                  $display("FAIL: %0d miscompares", miscompares);
        $finish;
    end

endmodule

// File: doc/picmicro_interrupt_controller.md
PICMICRO_INTERRUPT_CONTROLLER -- requirements
Module: picmicro_interrupt_controller

Interface
REQ-001 The block SHALL have one clock, clk, with reset rst synchronous and active-high.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- instr_boundary  in  1  one-cycle pulse from the decoder on the final cycle of each instruction.
- retfie_exec  in  1  one-cycle pulse when RETFIE completes.
- sleep_active  in  1  core is in SLEEP.
- intcon_reg_val  in  8  INTCON: GIE[7], PEIE[6], T0IE[5], INTE[4], RBIE[3], T0IF[2], INTF[1], RBIF[0].
- pir1_reg_val  in  8  PIR1 flags.
- pie1_reg_val  in  8  PIE1 enables.
- tmr0if_set_en  in  1  TMR0 overflow pulse.
- int_pin  in  1  asynchronous RB0/INT pin.
- intedg  in  1  OPTION[6]; 1 = rising edge, 0 = falling edge.
- irq_take  out  1  force CALL 0x004 and flush the fetched instruction.
- gie_clr_en  out  1  clear INTCON.GIE.
- gie_set_en  out  1  set INTCON.GIE.
- t0if_set_en  out  1  set INTCON.T0IF.
- intf_set_en  out  1  set INTCON.INTF.
- wake_req  out  1  exit SLEEP.
- irq_busy  out  1  ISR is in progress.
REQ-003 The block SHALL have no parameters: name — default — meaning: none.

Function
REQ-004 irq_cond SHALL be GIE & ((T0IE&T0IF) | (INTE&INTF) | (RBIE&RBIF) | (PEIE & |(pir1_reg_val & pie1_reg_val))).
REQ-005 enabled_flag SHALL be the same expression as irq_cond with the GIE term removed.
REQ-006 The FSM SHALL have states IDLE, VECTOR and ISR.
REQ-007 IDLE -> VECTOR SHALL occur on a cycle where instr_boundary=1 and irq_cond=1; irq_cond without instr_boundary SHALL NOT change state.
REQ-008 In VECTOR, irq_take and gie_clr_en SHALL both be 1 for exactly one cycle, then the FSM SHALL go to ISR.
- Latency from the qualifying boundary cycle is 1 cycle.
REQ-009 irq_take SHALL be 0 in IDLE and in ISR.
- No nesting: irq_cond and instr_boundary are ignored in ISR.
REQ-010 In ISR, retfie_exec=1 SHALL go to IDLE and pulse gie_set_en for one cycle, on the cycle after retfie_exec.
REQ-011 retfie_exec in IDLE or VECTOR SHALL still pulse gie_set_en one cycle later, with no state change.
REQ-012 irq_busy SHALL be 1 in VECTOR and ISR, and 0 in IDLE.
REQ-013 When retfie_exec and instr_boundary with irq_cond occur in the same cycle in ISR, the FSM SHALL go to IDLE.
- The interrupt is taken no earlier than the next instr_boundary after that.
REQ-014 t0if_set_en SHALL be tmr0if_set_en registered once (1-cycle latency, 1-cycle pulse per input pulse).
REQ-015 wake_req SHALL be registered (sleep_active & enabled_flag).
- It updates every cycle, independent of GIE and FSM state.
REQ-016 irq_take while sleep_active=1 SHALL only occur via a subsequent instr_boundary.
- The decoder issues that boundary after wake.

Reset
REQ-017 On rst=1 at a clk edge, the following SHALL hold:
- FSM=IDLE.
- All outputs 0.
- Synchronizer and edge-history flops 0.
- Any pending gie_set_en and t0if_set_en pulses discarded.
REQ-018 Reset asserted in VECTOR or ISR SHALL return the FSM to IDLE with irq_busy=0 on the next cycle, with no further pulses.

Configuration
REQ-019 The macro PICMICRO_INT_PIN_EN SHALL control the external-pin logic.
- Defined: int_pin passes a 2-flop synchronizer and a third history flop.
- Defined: an edge matching intedg pulses intf_set_en for one cycle.
- Defined: latency from a pin change to intf_set_en is 3 cycles.
- Defined: the first sample after reset never produces an edge.
- Undefined: int_pin and intedg are unused, intf_set_en is tied 0, and the synchronizer flops are not instantiated.

Verification
REQ-020 The bench SHALL cover these scenarios (stimulus -> required response):
- INTCON=0xA4 (GIE, T0IE, T0IF) in IDLE, instr_boundary pulse at cycle 10 -> irq_take=1 and gie_clr_en=1 at cycle 11 only; irq_busy=1 from cycle 11.
- In ISR, INTCON=0x24, retfie_exec at cycle 20 -> gie_set_en=1 at cycle 21, irq_busy=0 from cycle 21; no irq_take while in ISR.
- INTCON=0xC0, PIE1=0x01, PIR1=0x01, boundary pulse -> irq_take pulse; repeat with PIE1=0x00 -> no irq_take.
- sleep_active=1, INTCON=0x24 (GIE=0) -> wake_req=1 one cycle later and irq_take=0; clear T0IF -> wake_req=0 one cycle later.
- PICMICRO_INT_PIN_EN defined, intedg=1, int_pin 0->1 at cycle 5 -> intf_set_en=1 at cycle 8 only; intedg=0 with the same stimulus -> no pulse; macro undefined -> intf_set_en stays 0.
- rst asserted at the VECTOR cycle -> irq_take=0 next cycle, FSM=IDLE, gie_set_en never pulses.
